// File: rtl/store_checker_pkg.sv
// store_checker shared types: verdict state and fail code encodings.
package store_checker_pkg;

  // bit1 = verdict latched, bit0 = pass
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_FAIL = 2'b10,
    ST_PASS = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_BAD_ADDR = 2'd1,
    FC_BAD_DATA = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fc_t;

endpackage

// File: rtl/store_trace_fifo.sv
// Circular trace buffer; a push into a full buffer overwrites the
// oldest entry and sets the sticky overflow flag.
module store_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_req,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             drop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = (count != '0);
  assign pop   = pop_req && valid;
  assign drop  = push && full && !pop;
  assign dout  = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop || drop)
        rptr <= rptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      if (push && !pop && !full)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/store_checker.sv
// Store-bus self-check with sticky pass/fail verdict and diagnostics.
// Trace FIFO is built only when STORE_CHECKER_TRACE_EN is defined.
module store_checker
  import store_checker_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOW_ADDR     = 32'd96,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          TRACE_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [31:0] cycle_count,
  output logic [15:0] store_count,
  input  logic        trace_rd_en,
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);

  state_t state;
  fc_t    code;
  logic   run;
  logic   st;
  logic   hit_pass;
  logic   hit_bad_data;
  logic   hit_bad_addr;
  logic   tmo;

  assign run = (state == ST_RUN);
  assign st  = MemWrite && run;

  assign hit_pass     = st && Adr == PASS_ADDR
                           && WriteData == PASS_DATA;
  assign hit_bad_data = st && Adr == PASS_ADDR
                           && WriteData != PASS_DATA;
  assign hit_bad_addr = st && Adr != PASS_ADDR
                           && Adr != ALLOW_ADDR;
  // a decisive store on the timeout edge takes precedence
  assign tmo = run
    && cycle_count == 32'(TIMEOUT_CYCLES - 1)
    && !(hit_pass || hit_bad_data || hit_bad_addr);

  assign done      = state[1];
  assign pass      = state[0];
  assign fail_code = code;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      code        <= FC_NONE;
      fail_addr   <= '0;
      fail_data   <= '0;
      cycle_count <= '0;
      store_count <= '0;
    end else if (run) begin
      cycle_count <= cycle_count + 1'b1;
      if (MemWrite && store_count != 16'hFFFF)
        store_count <= store_count + 1'b1;
      unique case (1'b1)
        hit_pass: state <= ST_PASS;
        hit_bad_data: begin
          state     <= ST_FAIL;
          code      <= FC_BAD_DATA;
          fail_addr <= Adr;
          fail_data <= WriteData;
        end
        hit_bad_addr: begin
          state     <= ST_FAIL;
          code      <= FC_BAD_ADDR;
          fail_addr <= Adr;
          fail_data <= WriteData;
        end
        tmo: begin
          state <= ST_FAIL;
          code  <= FC_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

`ifdef STORE_CHECKER_TRACE_EN
  logic [63:0] tr_dout;

  store_trace_fifo #(
    .DEPTH(TRACE_DEPTH),
    .WIDTH(64)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .push    (st),
    .din     ({Adr, WriteData}),
    .pop_req (trace_rd_en),
    .valid   (trace_valid),
    .dout    (tr_dout),
    .overflow(trace_overflow)
  );

  assign trace_addr = tr_dout[63:32];
  assign trace_data = tr_dout[31:0];
`else
  logic unused_rd_en;

  assign unused_rd_en   = trace_rd_en;
  assign trace_valid    = 1'b0;
  assign trace_addr     = '0;
  assign trace_data     = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: vector table plus
// timeout, reset and trace sequences.
module tb_store_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = '0;
  logic [31:0] WriteData = '0;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data, cycle_count;
  logic [15:0] store_count;
  logic        trace_rd_en = 1'b0;
  logic        trace_valid, trace_overflow;
  logic [31:0] trace_addr, trace_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  store_checker #(
    .TIMEOUT_CYCLES(20),
    .TRACE_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail_code(fail_code),
    .fail_addr(fail_addr), .fail_data(fail_data),
    .cycle_count(cycle_count), .store_count(store_count),
    .trace_rd_en(trace_rd_en), .trace_valid(trace_valid),
    .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_overflow(trace_overflow)
  );

  typedef struct {
    logic        rst;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        e_done;
    logic        e_pass;
    logic [1:0]  e_code;
    logic [15:0] e_sc;
    logic [31:0] e_fa;
    logic [31:0] e_fd;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic mw, input logic [31:0] a,
                       input logic [31:0] d);
    MemWrite  = mw;
    Adr       = a;
    WriteData = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vt[0] = '{1, 0,   0, 0, 0, 0, 0, 0,   0, 0};
    vt[1] = '{0, 1,  96, 5, 0, 0, 0, 1,   0, 0};
    vt[2] = '{0, 1, 100, 7, 1, 1, 0, 2,   0, 0};
    vt[3] = '{1, 0,   0, 0, 0, 0, 0, 0,   0, 0};
    vt[4] = '{0, 1, 100, 8, 1, 0, 2, 1, 100, 8};
    vt[5] = '{1, 0,   0, 0, 0, 0, 0, 0,   0, 0};
    vt[6] = '{0, 1, 104, 7, 1, 0, 1, 1, 104, 7};
    vt[7] = '{0, 1, 100, 7, 1, 0, 1, 1, 104, 7};
    vt[8] = '{1, 0,   0, 0, 0, 0, 0, 0,   0, 0};
    vt[9] = '{0, 1, 100, 7, 1, 1, 0, 1,   0, 0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      reset = vt[i].rst;
      drive(vt[i].mw, vt[i].adr, vt[i].wd);
      tick();
      chk($sformatf("v%0d done", i), 32'(done), 32'(vt[i].e_done));
      chk($sformatf("v%0d pass", i), 32'(pass), 32'(vt[i].e_pass));
      chk($sformatf("v%0d code", i), 32'(fail_code),
          32'(vt[i].e_code));
      chk($sformatf("v%0d stores", i), 32'(store_count),
          32'(vt[i].e_sc));
      chk($sformatf("v%0d faddr", i), fail_addr, vt[i].e_fa);
      chk($sformatf("v%0d fdata", i), fail_data, vt[i].e_fd);
    end
    reset = 1'b0;
    drive(1'b0, 0, 0);

    // reset after PASS clears everything
    tick();
    chk("prerst pass", 32'(pass), 1);
    do_reset();
    chk("rst done", 32'(done), 0);
    chk("rst cycles", cycle_count, 0);
    chk("rst stores", 32'(store_count), 0);
    chk("rst tvalid", 32'(trace_valid), 0);

    // timeout: 19 idle edges leave RUN with count 19
    do_reset();
    for (int i = 0; i < 19; i++) tick();
    chk("tmo cnt19", cycle_count, 19);
    chk("tmo notyet", 32'(done), 0);
    tick();
    chk("tmo done", 32'(done), 1);
    chk("tmo pass", 32'(pass), 0);
    chk("tmo code", 32'(fail_code), 3);
    chk("tmo faddr", fail_addr, 0);
    chk("tmo fdata", fail_data, 0);
    tick();
    chk("tmo frozen", cycle_count, 20);

    // decisive store on the timeout edge wins
    do_reset();
    for (int i = 0; i < 19; i++) tick();
    drive(1'b1, 100, 7);
    tick();
    drive(1'b0, 0, 0);
    chk("tie done", 32'(done), 1);
    chk("tie pass", 32'(pass), 1);
    chk("tie code", 32'(fail_code), 0);

    // allowed store on the timeout edge does not prevent timeout
    do_reset();
    for (int i = 0; i < 19; i++) tick();
    drive(1'b1, 96, 3);
    tick();
    drive(1'b0, 0, 0);
    chk("tmo96 code", 32'(fail_code), 3);
    chk("tmo96 stores", 32'(store_count), 1);

    // trace: nine stores into a depth-8 buffer
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 96, 32'(k));
      tick();
    end
    drive(1'b0, 0, 0);
    chk("tr stores", 32'(store_count), 9);
    chk("tr done", 32'(done), 0);
`ifdef STORE_CHECKER_TRACE_EN
    chk("tr ovf", 32'(trace_overflow), 1);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("tr valid%0d", k), 32'(trace_valid), 1);
      chk($sformatf("tr addr%0d", k), trace_addr, 96);
      chk($sformatf("tr data%0d", k), trace_data, 32'(k));
      trace_rd_en = 1'b1;
      tick();
      trace_rd_en = 1'b0;
    end
    chk("tr empty", 32'(trace_valid), 0);
    chk("tr empty addr", trace_addr, 0);
    chk("tr empty data", trace_data, 0);
    trace_rd_en = 1'b1;
    tick();
    trace_rd_en = 1'b0;
    chk("tr pop empty", 32'(trace_valid), 0);
    chk("tr ovf sticky", 32'(trace_overflow), 1);
    do_reset();
    chk("tr rst ovf", 32'(trace_overflow), 0);
    chk("tr rst valid", 32'(trace_valid), 0);
`else
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("notr valid%0d", k), 32'(trace_valid), 0);
      chk($sformatf("notr addr%0d", k), trace_addr, 0);
      chk($sformatf("notr data%0d", k), trace_data, 0);
      chk($sformatf("notr ovf%0d", k), 32'(trace_overflow), 0);
      trace_rd_en = 1'b1;
      tick();
      trace_rd_en = 1'b0;
    end
`endif

    // reset then PASS again
    do_reset();
    drive(1'b1, 100, 7);
    tick();
    drive(1'b0, 0, 0);
    chk("again pass", 32'(pass), 1);
    chk("again done", 32'(done), 1);
    chk("again stores", 32'(store_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_checker.md
# store_checker

Synthesizable self-check stage that sits directly downstream of the processor `top` memory write bus (`MemWrite`, `Adr`, `WriteData`). It watches every store, classifies it against a programmed pass/allowed address pair, and latches a sticky pass/fail verdict with diagnostics. This lets FPGA builds and benches share one pass criterion without `$display`/`$stop`.

## Interface
- `PASS_ADDR`, default 100: a store here with `PASS_DATA` ends the run as a pass.
- `PASS_DATA`, default 7: required data at `PASS_ADDR`.
- `ALLOW_ADDR`, default 96: stores here are legal and counted, with no verdict.
- `TIMEOUT_CYCLES`, default 1000: RUN cycles allowed before the timeout fail; must be ≥ 2.
- `TRACE_DEPTH`, default 8: trace FIFO entries; power of 2, ≥ 2.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `MemWrite` in 1: store strobe from `top`.
- `Adr` in 32: store address.
- `WriteData` in 32: store data.
- `done` out 1: the verdict is latched.
- `pass` out 1: the verdict is pass; valid only when `done`=1.
- `fail_code` out 2: 0 none, 1 illegal address, 2 wrong data at `PASS_ADDR`, 3 timeout.
- `fail_addr` out 32: `Adr` of the failing store; 0 for timeout.
- `fail_data` out 32: `WriteData` of the failing store; 0 for timeout.
- `cycle_count` out 32: number of RUN cycles.
- `store_count` out 16: number of stores sampled in RUN; saturates at 0xFFFF.
- `trace_rd_en` in 1: pop one trace entry.
- `trace_valid` out 1: a trace entry is available.
- `trace_addr` out 32: address of the oldest trace entry.
- `trace_data` out 32: data of the oldest trace entry.
- `trace_overflow` out 1: sticky flag; set when an entry was overwritten.

## Operation
- States: RUN, PASS, FAIL.
  - `reset`=1 forces RUN, including mid-run or after a verdict.
  - Reset zeroes every output and counter and empties the trace.
- Behaviour in RUN, for each rising edge with `MemWrite`=1:
  - `Adr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  - `Adr`==`PASS_ADDR` with other data → FAIL, code 2.
  - `Adr`==`ALLOW_ADDR` (any data) → stay in RUN.
  - Any other address → FAIL, code 1. Capture `fail_addr`/`fail_data`.
  - Every store sampled in RUN, including the decisive one, increments `store_count`.
- Timeout: `cycle_count` increments every RUN cycle. On the edge where it equals `TIMEOUT_CYCLES`-1 with no decisive store, go to FAIL with code 3.
- Simultaneous events: a decisive store on the timeout edge wins; the timeout is not reported.
- PASS/FAIL are terminal until reset.
  - `cycle_count` and `store_count` freeze there.
  - Further `MemWrite` pulses are ignored.
- `done` = (state≠RUN). `pass` = (state==PASS).

## Timing
- All outputs are registered.
- A verdict is visible in the cycle after the store cycle, i.e. 1 cycle latency from the sampling edge.
- `Adr`/`WriteData` are sampled only when `MemWrite`=1 at the rising edge. There is no handshake back to `top`, and the block never stalls the processor.
- Trace FIFO:
  - A push happens on each store sampled in RUN.
  - A pop happens on `trace_rd_en` && `trace_valid`. `trace_rd_en` while empty is ignored.
  - Push into a full FIFO with no pop: the oldest entry is overwritten, read pointer advances, `trace_overflow` set.
  - Simultaneous push and pop when full: normal pop plus push, no overflow.
  - `trace_addr`/`trace_data` show the oldest entry combinationally from registered storage. Their value is 0 when empty.

## Configuration
- `STORE_CHECKER_TRACE_EN` defined: the trace FIFO is instantiated as specified above.
- Macro undefined: the FIFO is not built; trace ports remain present.
  - `trace_valid`, `trace_addr`, `trace_data` and `trace_overflow` are tied to 0.
  - `trace_rd_en` is ignored.
  - Verdict behaviour is identical in both builds.

## Structure
- Package `store_checker_pkg` holds:
  - the state enum (RUN, PASS, FAIL);
  - the `fail_code` enum: FC_NONE=0, FC_BAD_ADDR=1, FC_BAD_DATA=2, FC_TIMEOUT=3.
- One sub-module: `store_trace_fifo`, a circular buffer parameterized by depth and width (64 = addr+data).
  - It implements the overwrite-on-full rule and owns `trace_overflow`.

## Test plan
- Store 96/5, then 100/7 → `store_count`=2; `done`=1, `pass`=1, `fail_code`=0 in the cycle after the second store.
- Store 100/8 → `done`=1, `pass`=0, `fail_code`=2, `fail_addr`=100, `fail_data`=8.
- Store 104/7 → `fail_code`=1, `fail_addr`=104; a following 100/7 store leaves the verdict and `store_count`=1 unchanged.
- Timeout:
  - With `TIMEOUT_CYCLES`=20 and no stores → FAIL, code 3, after `cycle_count` reaches 19; `fail_addr`=0.
  - A 100/7 store exactly on that edge instead → PASS.
- Reset:
  - Assert `reset` for 1 cycle after PASS → `done`=0, counters 0, trace empty.
  - Then 100/7 → PASS again.
- Trace (`STORE_CHECKER_TRACE_EN`, `TRACE_DEPTH`=8):
  - Nine 96/k stores (k=1..9) → `trace_overflow`=1; pops read data 2..9 in order, then `trace_valid`=0.
  - Without the macro → all trace outputs stay 0.
